// File: rtl/usb_bitstuff_nrzi_pkg.sv
// usb_bitstuff_nrzi_pkg: shared state/line types and line-level decoding for the USB transmit back end
package usb_bitstuff_nrzi_pkg;

    typedef enum logic [2:0] {IDLE, SEND, STUFF, EOP_SE0, EOP_J} tx_state_t;

    typedef enum logic [1:0] {LINE_SE0, LINE_J, LINE_K} line_t;

    // Full speed idles with D+ high, low speed with D- high; SE0 is both low either way.
    function automatic logic [1:0] line_to_dpdm(input line_t l, input logic low_speed);
        return l == LINE_SE0 ? 2'b00 : ((l == LINE_J) ^ low_speed) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/usb_bitstuff_nrzi_if.sv
// usb_bitstuff_nrzi_if: serial bit handshake from the packet PISO into the stuffer/encoder
interface usb_bitstuff_nrzi_if;

    logic in_bit;
    logic in_valid;
    logic in_last;
    logic in_ready;

    modport master (output in_bit, output in_valid, output in_last, input in_ready);
    modport slave  (input in_bit, input in_valid, input in_last, output in_ready);

endinterface

// File: rtl/usb_bitstuff_nrzi_line.sv
// usb_bitstuff_nrzi_line: NRZI line-level register driving registered dp/dm
module usb_bitstuff_nrzi_line
    import usb_bitstuff_nrzi_pkg::*;
#(
    parameter bit LOW_SPEED = 1'b0
) (
    input  logic clk,
    input  logic rst_b,
    input  logic toggle,
    input  logic force_se0,
    input  logic force_j,
    output logic dp,
    output logic dm
);

    line_t level;
    line_t level_n;

    // Next level: SE0 and J overrides win, otherwise a toggle flips J/K and anything else holds.
    always_comb level_n = force_se0 ? LINE_SE0 : force_j ? LINE_J :
                          toggle ? (level == LINE_J ? LINE_K : LINE_J) : level;

    // Keep the symbolic level and the decoded pins in step so dp/dm come straight from flops.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            level    <= LINE_J;
            {dp, dm} <= line_to_dpdm(LINE_J, LOW_SPEED);
        end else begin
            level    <= level_n;
            {dp, dm} <= line_to_dpdm(level_n, LOW_SPEED);
        end
    end

endmodule

// File: rtl/usb_bitstuff_nrzi.sv
// usb_bitstuff_nrzi: bit stuffing, NRZI encoding and EOP generation for the USB host transmitter
module usb_bitstuff_nrzi
    import usb_bitstuff_nrzi_pkg::*;
#(
    parameter int unsigned STUFF_LEN      = 6,
    parameter int unsigned EOP_SE0_CYCLES = 2,
    parameter bit          LOW_SPEED      = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_b,
    usb_bitstuff_nrzi_if.slave   bus,
    output logic                 dp,
    output logic                 dm,
    output logic                 out_en,
    output logic                 busy,
    output logic                 abort
);

    localparam int OW = $clog2(STUFF_LEN + 1);
    localparam int EW = $clog2(EOP_SE0_CYCLES + 1);

    tx_state_t     state;
    logic [OW-1:0] ones;
    logic [OW-1:0] ones_n;
    logic [EW-1:0] eop_cnt;
    logic          stuff_last;
    logic          accept;
    logic          stuff_hit;
    logic          toggle;
    logic          force_se0;
    logic          force_j;
    logic          eop_done;

    assign bus.in_ready = state == IDLE || state == SEND;

    // Line actions for this edge; an abort drives SE0 at once so no phantom bit is held on the wire.
    always_comb begin
        accept    = bus.in_valid && bus.in_ready;
        ones_n    = bus.in_bit ? (state == IDLE ? OW'(1) : ones + OW'(1)) : '0;
        stuff_hit = accept && ones_n == OW'(STUFF_LEN);
        toggle    = (accept && !bus.in_bit) || state == STUFF;
        force_se0 = state == EOP_SE0 || (state == SEND && !bus.in_valid);
        force_j   = state == EOP_J || (state == IDLE && !bus.in_valid);
        eop_done  = eop_cnt + EW'(1) == EW'(EOP_SE0_CYCLES);
    end

    // Packet FSM with ones/EOP counters; out_en and busy describe the level driven after this edge.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= IDLE;
            ones       <= '0;
            eop_cnt    <= '0;
            stuff_last <= 1'b0;
            out_en     <= 1'b0;
            busy       <= 1'b0;
            abort      <= 1'b0;
        end else begin
            abort <= 1'b0;
            if (accept) begin
                state      <= stuff_hit ? STUFF : bus.in_last ? EOP_SE0 : SEND;
                ones       <= ones_n;
                stuff_last <= bus.in_last;
                out_en     <= 1'b1;
                busy       <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        out_en <= 1'b0;
                        busy   <= 1'b0;
                        ones   <= '0;
                    end
                    SEND: begin
                        state   <= EOP_SE0_CYCLES == 1 ? EOP_J : EOP_SE0;
                        eop_cnt <= EOP_SE0_CYCLES == 1 ? '0 : EW'(1);
                        abort   <= 1'b1;
                    end
                    STUFF: begin
                        state <= stuff_last ? EOP_SE0 : SEND;
                        ones  <= '0;
                    end
                    EOP_SE0: begin
                        state   <= eop_done ? EOP_J : EOP_SE0;
                        eop_cnt <= eop_done ? '0 : eop_cnt + EW'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    usb_bitstuff_nrzi_line #(.LOW_SPEED(LOW_SPEED)) u_line (
        .clk       (clk),
        .rst_b     (rst_b),
        .toggle    (toggle),
        .force_se0 (force_se0),
        .force_j   (force_j),
        .dp        (dp),
        .dm        (dm)
    );

endmodule

// File: tb/tb_usb_bitstuff_nrzi.sv
// tb_usb_bitstuff_nrzi: directed checks of stuffing, NRZI, EOP, abort and reset on full- and low-speed instances
module tb_usb_bitstuff_nrzi;

    localparam logic [1:0] J = 2'b10;
    localparam logic [1:0] K = 2'b01;
    localparam logic [1:0] S = 2'b00;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    logic in_bit = 1'b0;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;

    logic fs_dp, fs_dm, fs_oe, fs_busy, fs_ab;
    logic ls_dp, ls_dm, ls_oe, ls_busy, ls_ab;

    int n_chk = 0;
    int n_err = 0;

    logic [4:0] q[$];

    always #5 clk = ~clk;

    usb_bitstuff_nrzi_if fs ();
    usb_bitstuff_nrzi_if ls ();

    assign fs.in_bit   = in_bit;
    assign fs.in_valid = in_valid;
    assign fs.in_last  = in_last;
    assign ls.in_bit   = in_bit;
    assign ls.in_valid = in_valid;
    assign ls.in_last  = in_last;

    usb_bitstuff_nrzi #(.LOW_SPEED(1'b0)) dut_fs (
        .clk(clk), .rst_b(rst_b), .bus(fs),
        .dp(fs_dp), .dm(fs_dm), .out_en(fs_oe), .busy(fs_busy), .abort(fs_ab)
    );

    usb_bitstuff_nrzi #(.LOW_SPEED(1'b1)) dut_ls (
        .clk(clk), .rst_b(rst_b), .bus(ls),
        .dp(ls_dp), .dm(ls_dm), .out_en(ls_oe), .busy(ls_busy), .abort(ls_ab)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Low speed swaps J and K; SE0 is unchanged.
    function automatic logic [1:0] to_ls(input logic [1:0] l);
        return l == S ? S : ~l;
    endfunction

    // One expected cycle: ready before the edge, out_en/busy, abort and full-speed line after it.
    function automatic logic [4:0] ent(input logic rdy, input logic oe, input logic ab, input logic [1:0] l);
        return {rdy, oe, ab, l};
    endfunction

    // Source honours the expected ready; bit i is held until the bench's model says it was taken.
    task automatic run(input string name, input logic [15:0] bits, input logic [15:0] lasts, input int n);
        int i = 0;
        foreach (q[k]) begin
            in_valid = i < n;
            in_bit   = in_valid ? bits[i] : 1'b0;
            in_last  = in_valid ? lasts[i] : 1'b0;
            check($sformatf("%s c%0d rdy", name, k), {6'd0, fs.in_ready, ls.in_ready}, {6'd0, {2{q[k][4]}}});
            if (in_valid && q[k][4]) i++;
            @(posedge clk);
            #1;
            check($sformatf("%s c%0d fs", name, k), {3'd0, fs_oe, fs_busy, fs_ab, fs_dp, fs_dm},
                  {3'd0, q[k][3], q[k][3], q[k][2], q[k][1:0]});
            check($sformatf("%s c%0d ls", name, k), {3'd0, ls_oe, ls_busy, ls_ab, ls_dp, ls_dm},
                  {3'd0, q[k][3], q[k][3], q[k][2], to_ls(q[k][1:0])});
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        #12;
        check("rst fs", {3'd0, fs.in_ready, fs_oe, fs_busy, fs_ab, fs_dp, fs_dm}, {3'd0, 1'b1, 3'b000, J});
        check("rst ls line", {6'd0, ls_dp, ls_dm}, 8'h01);
        rst_b = 1'b1;
        @(posedge clk);
        #1;

        in_valid = 1'b1;
        in_bit   = 1'b0;
        @(posedge clk);
        #1;
        check("midrst pre", {5'd0, fs_oe, fs_dp, fs_dm}, {5'd0, 1'b1, K});
        #2 rst_b = 1'b0;
        #1;
        check("midrst fs", {3'd0, fs.in_ready, fs_oe, fs_busy, fs_ab, fs_dp, fs_dm}, {3'd0, 1'b1, 3'b000, J});
        check("midrst ls", {5'd0, ls_oe, ls_dp, ls_dm}, 8'h01);
        in_valid = 1'b0;
        #1 rst_b = 1'b1;
        @(posedge clk);
        #1;
        check("midrst no eop", {5'd0, fs_oe, fs_dp, fs_dm}, {5'd0, 1'b0, J});

        q = '{ent(1,1,0,K), ent(1,1,0,K), ent(1,1,0,K), ent(1,1,0,J),
              ent(0,1,0,S), ent(0,1,0,S), ent(0,1,0,J), ent(1,0,0,J)};
        run("p0110", 16'b0110, 16'b1000, 4);

        q = '{ent(1,1,0,J), ent(1,1,0,J), ent(1,1,0,J), ent(1,1,0,J), ent(1,1,0,J), ent(1,1,0,J),
              ent(0,1,0,K), ent(1,1,0,K), ent(1,1,0,J),
              ent(0,1,0,S), ent(0,1,0,S), ent(0,1,0,J), ent(1,0,0,J)};
        run("seven1", 16'h007F, 16'h0080, 8);

        q = '{ent(1,1,0,J), ent(1,1,0,J), ent(1,1,0,J), ent(1,1,0,J), ent(1,1,0,J), ent(1,1,0,J),
              ent(0,1,0,K), ent(0,1,0,S), ent(0,1,0,S), ent(0,1,0,J), ent(1,0,0,J)};
        run("six1last", 16'h003F, 16'h0020, 6);

        q = '{ent(1,1,0,J), ent(1,1,0,K), ent(1,1,0,K), ent(1,1,1,S),
              ent(0,1,0,S), ent(0,1,0,J), ent(1,0,0,J)};
        run("abort", 16'b101, 16'b000, 3);

        q = '{ent(1,1,0,K), ent(1,1,0,J), ent(0,1,0,S), ent(0,1,0,S), ent(0,1,0,J),
              ent(1,1,0,J), ent(1,1,0,K), ent(0,1,0,S), ent(0,1,0,S), ent(0,1,0,J), ent(1,0,0,J)};
        run("b2b", 16'b0100, 16'b1010, 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
